// File: rtl/packing_station_arbiter.sv
// Round-robin arbiter sharing one sock packing station between N_LINES request lines.
// Holds the grant for a fixed pack time, pulses ack to the owner and counts completed packs.
module packing_station_arbiter #(
    parameter int unsigned N_LINES     = 4,
    parameter int unsigned PACK_CYCLES = 5,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic [N_LINES-1:0]     req_i,
    input  logic [3*N_LINES-1:0]   pac_code_i,
    output logic [N_LINES-1:0]     grant_o,
    output logic [N_LINES-1:0]     ack_o,
    output logic                   busy_o,
    output logic [2:0]             pac_out_o,
    output logic                   pac_valid_o,
    output logic [CNT_W-1:0]       total_packs_o,
    output logic [1:0]             state_o
);

    localparam int unsigned IdxW = $clog2(N_LINES);
    localparam int unsigned TmrW = (PACK_CYCLES > 1) ? $clog2(PACK_CYCLES) : 1;
    localparam logic [IdxW-1:0] LastInit = IdxW'(N_LINES - 1);
    localparam logic [TmrW-1:0] TmrInit  = TmrW'(PACK_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StGrant   = 2'b01,
        StPack    = 2'b10,
        StRelease = 2'b11
    } state_e;

    state_e             state_q;
    logic [N_LINES-1:0] grant_q;
    logic [N_LINES-1:0] ack_q;
    logic [IdxW-1:0]    owner_q;
    logic [IdxW-1:0]    last_q;
    logic [TmrW-1:0]    timer_q;
    logic [2:0]         pac_out_q;
    logic               pac_valid_q;
    logic [CNT_W-1:0]   total_q;

    logic [2:0]         codes [N_LINES];
    logic               pick_valid;
    logic [IdxW-1:0]    pick_idx;
    logic [IdxW-1:0]    scan_idx;

    always_comb begin
        for (int unsigned i = 0; i < N_LINES; i++) begin
            codes[i] = pac_code_i[3*i +: 3];
        end
    end

    // Search starts just after the last owner so every line gets a turn.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned k = 1; k <= N_LINES; k++) begin
            scan_idx = IdxW'((32'(last_q) + k) % N_LINES);
            if (!pick_valid && req_i[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            ack_q       <= '0;
            owner_q     <= '0;
            last_q      <= LastInit;
            timer_q     <= '0;
            pac_out_q   <= '0;
            pac_valid_q <= 1'b0;
            total_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable_i && pick_valid) begin
                        grant_q     <= N_LINES'(1) << pick_idx;
                        owner_q     <= pick_idx;
                        pac_out_q   <= codes[pick_idx];
                        pac_valid_q <= 1'b1;
                        state_q     <= StGrant;
                    end
                end
                StGrant: begin
                    pac_valid_q <= 1'b0;
                    timer_q     <= TmrInit;
                    state_q     <= StPack;
                end
                StPack: begin
                    if (timer_q == '0) begin
                        ack_q   <= grant_q;
                        state_q <= StRelease;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                StRelease: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    last_q  <= owner_q;
                    if (total_q != '1) begin
                        total_q <= total_q + 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign ack_o         = ack_q;
    assign busy_o        = (state_q != StIdle);
    assign pac_out_o     = pac_out_q;
    assign pac_valid_o   = pac_valid_q;
    assign total_packs_o = total_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_packing_station_arbiter.sv
// Bench for packing_station_arbiter: directed scenarios plus random traffic,
// every cycle compared against a job-level model of the station.
module tb_packing_station_arbiter;

    localparam int N = 4;
    localparam int P = 5;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req;
    logic [3*N-1:0] pac_code;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           busy;
    logic [2:0]     pac_out;
    logic           pac_valid;
    logic [W-1:0]   total_packs;
    logic [1:0]     state;

    int total = 0;
    int bad   = 0;

    // Model: current owner (-1 idle), cycle number within the job (1..P+2).
    int         m_owner;
    int         m_cyc;
    int         m_last;
    logic [W-1:0] m_total;
    logic [2:0] m_pac;

    packing_station_arbiter #(
        .N_LINES    (N),
        .PACK_CYCLES(P),
        .CNT_W      (W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (en),
        .req_i        (req),
        .pac_code_i   (pac_code),
        .grant_o      (grant),
        .ack_o        (ack),
        .busy_o       (busy),
        .pac_out_o    (pac_out),
        .pac_valid_o  (pac_valid),
        .total_packs_o(total_packs),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cyc   = 0;
        m_last  = N - 1;
        m_total = '0;
        m_pac   = '0;
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        if (m_owner < 0) begin
            if (en && req != '0) begin
                m_owner = rr_pick();
                m_cyc   = 1;
                m_pac   = pac_code[3*m_owner +: 3];
            end
        end else if (m_cyc == P + 2) begin
            m_last  = m_owner;
            if (m_total != '1) m_total = m_total + 1'b1;
            m_owner = -1;
            m_cyc   = 0;
        end else begin
            m_cyc++;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        logic [1:0]   es;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        if (m_owner < 0)        es = 2'b00;
        else if (m_cyc == 1)    es = 2'b01;
        else if (m_cyc == P + 2) es = 2'b11;
        else                    es = 2'b10;
        check("grant", 32'(grant), 32'(eg));
        check("ack", 32'(ack), (m_owner >= 0 && m_cyc == P + 2) ? 32'(eg) : 32'd0);
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("pac_out", 32'(pac_out), 32'(m_pac));
        check("pac_valid", 32'(pac_valid), 32'(m_owner >= 0 && m_cyc == 1));
        check("total_packs", 32'(total_packs), 32'(m_total));
        check("state", 32'(state), 32'(es));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [N-1:0] seq [$];
        logic [N-1:0] prev_g;
        int gcnt;
        int acnt;
        int guard;

        // Reset held with all lines requesting.
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = 4'b1111;
        pac_code = 12'($urandom);
        model_reset();
        #2;
        compare_all();
        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);

        // Release: line 0 first, then fairness with req held.
        rst_n = 1'b1;
        step();
        check("first_grant", 32'(grant), 32'b0001);
        prev_g = grant;
        seq.push_back(grant);
        repeat (5 * (P + 3)) begin
            step();
            if (prev_g == '0 && grant != '0) seq.push_back(grant);
            prev_g = grant;
        end
        check("fair_len_ok", 32'(seq.size() >= 5), 32'd1);
        if (seq.size() >= 5) begin
            check("fair0", 32'(seq[0]), 32'b0001);
            check("fair1", 32'(seq[1]), 32'b0010);
            check("fair2", 32'(seq[2]), 32'b0100);
            check("fair3", 32'(seq[3]), 32'b1000);
            check("fair4", 32'(seq[4]), 32'b0001);
        end
        req = '0;
        repeat (P + 4) step();

        // Single request from line 2 with code 011; line clears req on ack.
        pac_code = 12'b000_011_101_110;
        req      = 4'b0100;
        gcnt     = 0;
        acnt     = 0;
        repeat (P + 6) begin
            step();
            if (grant == 4'b0100) gcnt++;
            if (pac_valid) check("single_pac", 32'(pac_out), 32'b011);
            if (ack == 4'b0100) begin
                acnt++;
                req = '0;
            end
        end
        check("single_gcycles", 32'(gcnt), 32'(P + 2));
        check("single_acks", 32'(acnt), 32'd1);

        // Enable gating: no grant while disabled.
        en   = 1'b0;
        req  = 4'b0010;
        gcnt = 0;
        repeat (20) begin
            step();
            if (grant != '0) gcnt++;
        end
        check("gated_no_grant", 32'(gcnt), 32'd0);

        // Drop enable mid-PACK: job still completes, nothing further.
        en    = 1'b1;
        guard = 0;
        while (state != 2'b10 && guard < 10) begin
            step();
            guard++;
        end
        check("reach_pack", 32'(state), 32'b10);
        step();
        en   = 1'b0;
        acnt = 0;
        gcnt = 0;
        repeat (P + 8) begin
            step();
            if (ack == 4'b0010) acnt++;
            if (acnt > 0 && ack == '0 && grant != '0) gcnt++;
        end
        check("gated_job_ack", 32'(acnt), 32'd1);
        check("gated_no_regrant", 32'(gcnt), 32'd0);

        // Async reset in PACK cycle 3, between edges.
        en    = 1'b1;
        req   = 4'b0001;
        guard = 0;
        while (state != 2'b10 && guard < 10) begin
            step();
            guard++;
        end
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pac", 32'(pac_out), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        compare_all();
        #3;
        req   = 4'b1010;
        rst_n = 1'b1;
        step();
        check("post_rst_line1", 32'(grant), 32'b0010);

        // Saturation: line 0 requesting continuously.
        req = 4'b0001;
        repeat (18 * (P + 3) + 4) step();
        check("sat_total", 32'(total_packs), 32'hF);

        // Random traffic.
        repeat (400) begin
            req      = N'($urandom);
            en       = ($urandom_range(0, 7) != 0);
            pac_code = 12'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
